// File: rtl/hamming.sv
// hamming: registered extended Hamming(32,26) SECDED encoder.
//   clock       in   1  rising-edge clock
//   reset       in   1  synchronous, active-high; clears parityData
//   data        in  26  raw data word, sampled every rising edge
//   parityData  out 32  codeword of the previous cycle's data
//                       bit p-1 = Hamming position p (1..31), bit 31 = overall parity
module hamming (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] data,
    output logic [31:0] parityData
);

    localparam int unsigned DATA_W  = 26;
    localparam int unsigned HAM_W   = 31;
    localparam int unsigned CHECK_N = 5;

    logic [HAM_W-1:0]   spread_c;  // data bits at their positions, check slots zero
    logic [CHECK_N-1:0] check_c;   // check bit k lives at position 2^k
    logic [HAM_W-1:0]   ham_c;     // Hamming(31,26) word
    logic [31:0]        next_c;

    // Scatter data into the non-power-of-two positions in ascending order.
    always_comb begin
        spread_c = {data[DATA_W-1:11], 1'b0, data[10:4], 1'b0, data[3:1], 1'b0, data[0], 2'b00};
    end

    // Even parity over every position whose index has bit k set.
    always_comb begin
        logic [4:0] pos;
        check_c = '0;
        pos     = '0;
        for (int k = 0; k < CHECK_N; k++) begin
            for (int b = 0; b < HAM_W; b++) begin
                pos = 5'(b + 1);
                if (pos[k]) begin
                    check_c[k] = check_c[k] ^ spread_c[b];
                end
            end
        end
    end

    // Drop check bits into their slots and add overall parity on top.
    always_comb begin
        ham_c      = spread_c;
        ham_c[0]   = check_c[0];
        ham_c[1]   = check_c[1];
        ham_c[3]   = check_c[2];
        ham_c[7]   = check_c[3];
        ham_c[15]  = check_c[4];
        next_c     = {^ham_c, ham_c};
    end

    // Output register; reset wins over encoding.
    always_ff @(posedge clock) begin
        if (reset) begin
            parityData <= '0;
        end else begin
            parityData <= next_c;
        end
    end

endmodule

// File: tb/tb_hamming.sv
// tb_hamming: scoreboard bench for the hamming encoder.
// Stimulus pushes the expected codeword per edge; a monitor pops and compares
// after each edge and re-checks that the output holds through the low phase.
module tb_hamming;

    logic        clock;
    logic        reset;
    logic [25:0] data;
    logic [31:0] parityData;

    int checks = 0;
    int fails  = 0;

    logic [31:0] expq[$];
    logic [31:0] last_exp;
    logic        have_last = 1'b0;
    bit          done      = 1'b0;

    hamming dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .parityData (parityData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the syndrome of a set data bit is its position index, so the
    // check bits are the XOR of the positions of all set data bits.
    function automatic logic [31:0] ref_encode(input logic [25:0] d);
        logic [31:0] w;
        logic [4:0]  syn;
        int          i;
        w   = '0;
        syn = '0;
        i   = 0;
        for (int p = 1; p <= 31; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p-1] = d[i];
                if (d[i]) syn = syn ^ 5'(p);
                i++;
            end
        end
        for (int k = 0; k < 5; k++) w[(1 << k) - 1] = syn[k];
        w[31] = ^w[30:0];
        return w;
    endfunction

    // One cycle: glitch the inputs, settle on the real values, push expectation at the edge.
    task automatic step(input logic [25:0] d, input logic r, input logic [31:0] exp);
        #1;
        data  = 26'($urandom);
        reset = 1'($urandom);
        #2;
        data  = d;
        reset = r;
        @(posedge clock);
        expq.push_back(exp);
    endtask

    // Monitor: compare after each edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clock);
            #2;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if (parityData !== e) begin
                    fails++;
                    $display("FAIL codeword: got %08h expected %08h (t=%0t)", parityData, e, $time);
                end
                checks++;
                if (^parityData !== 1'b0) begin
                    fails++;
                    $display("FAIL even_parity: got word %08h with odd parity (t=%0t)", parityData, $time);
                end
                last_exp  = e;
                have_last = 1'b1;
            end
        end
    end

    // Hold check: input glitches between edges must not reach the output.
    initial begin
        forever begin
            @(negedge clock);
            if (have_last && !done) begin
                checks++;
                if (parityData !== last_exp) begin
                    fails++;
                    $display("FAIL hold: got %08h expected %08h (t=%0t)", parityData, last_exp, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending %0d", expq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] d;
        data  = '0;
        reset = 1'b1;

        // Directed vectors.
        step(26'h155AA55, 1'b1, 32'h0000_0000);
        step(26'h0000000, 1'b0, 32'h0000_0000);
        step(26'h0000001, 1'b0, 32'h8000_0007);
        step(26'h0000002, 1'b0, 32'h8000_0019);
        step(26'h2000000, 1'b0, 32'h4000_808B);
        step(26'h3FFFFFF, 1'b0, 32'hFFFF_FFFF);
        step(26'h3FFFFFF, 1'b1, 32'h0000_0000);
        step(26'h0000001, 1'b0, 32'h8000_0007);

        // Back-to-back with reset mid-stream.
        for (int i = 0; i < 24; i++) begin
            d = 26'($urandom);
            if (i == 11) step(d, 1'b1, 32'h0000_0000);
            else         step(d, 1'b0, ref_encode(d));
        end

        // Random words against the reference model.
        for (int i = 0; i < 1000; i++) begin
            d = 26'($urandom);
            step(d, 1'b0, ref_encode(d));
        end

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clock);
        #3;
        done = 1'b1;
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
